// File: rtl/switch_debouncer_fsm_pkg.sv
// Shared definitions for the push-button conditioning blocks: debounce FSM
// state encodings, default 50 MHz timing constants and the input polarity helper.
package switch_debouncer_fsm_pkg;

   typedef enum logic [1:0] {
      REL    = 2'd0,
      WAIT_P = 2'd1,
      PRS    = 2'd2,
      WAIT_R = 2'd3
   } db_state_e;

   localparam int unsigned DB_10MS_50MHZ = 32'd500_000;
   localparam int unsigned LONG_1S_50MHZ = 32'd50_000_000;

   // Map a raw switch level onto "1 = pressed".
   function automatic logic sw_to_active(input logic sw_raw, input bit active_low);
      return active_low ? ~sw_raw : sw_raw;
   endfunction

endpackage

// File: rtl/switch_debouncer_fsm_sync_2ff.sv
// 1-bit two-flop synchronizer with asynchronous active-low reset to a
// configurable level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/switch_debouncer_fsm.sv
// Push-button conditioner: synchronizes a raw switch, debounces it with a
// 4-state FSM and emits a clean level plus rise/fall/long-press ticks.
module switch_debouncer_fsm
   import switch_debouncer_fsm_pkg::*;
#(
   parameter int unsigned DB_CYCLES     = DB_10MS_50MHZ,
   parameter int unsigned LONG_CYCLES   = LONG_1S_50MHZ,
   parameter bit          SW_ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw,
   output logic db,
   output logic rise_tick,
   output logic fall_tick,
   output logic long_tick
);

   localparam int unsigned DB_W   = $clog2(DB_CYCLES);
   localparam int unsigned LONG_W = $clog2(LONG_CYCLES);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

   logic sw_act;
   logic s;

   db_state_e         state_q,     state_d;
   logic [DB_W-1:0]   db_cnt_q,    db_cnt_d;
   logic [LONG_W-1:0] hold_cnt_q,  hold_cnt_d;
   logic              long_done_q, long_done_d;
   logic              db_q,        db_d;
   logic              rise_q,      rise_d;
   logic              fall_q,      fall_d;
   logic              long_q,      long_d;

   assign sw_act = sw_to_active(sw, SW_ACTIVE_LOW);

   sync_2ff #(
      .RST_VAL (1'b0)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sw_act),
      .q     (s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= REL;
         db_cnt_q    <= '0;
         hold_cnt_q  <= '0;
         long_done_q <= 1'b0;
         db_q        <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         db_cnt_q    <= db_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         long_done_q <= long_done_d;
         db_q        <= db_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         long_q      <= long_d;
      end
   end

   // The sample that moves the FSM into a WAIT state counts as the first
   // stable cycle, so db_cnt reaching DB_LAST means DB_CYCLES consecutive
   // samples were seen and the candidate is accepted on that edge.
   always_comb begin
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      long_done_d = long_done_q;
      db_d        = db_q;
      rise_d      = 1'b0;
      fall_d      = 1'b0;
      long_d      = 1'b0;

      case (state_q)
         REL: begin
            db_d = 1'b0;
            if (s) begin
               state_d  = WAIT_P;
               db_cnt_d = '0;
            end
         end

         WAIT_P: begin
            if (db_cnt_q == DB_LAST) begin
               state_d     = PRS;
               db_d        = 1'b1;
               rise_d      = 1'b1;
               hold_cnt_d  = '0;
               long_done_d = 1'b0;
            end else if (!s) begin
               state_d = REL;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end

         PRS: begin
            db_d = 1'b1;
            // hold_cnt parks at LONG_LAST; long_done keeps the tick to once per press.
            if (hold_cnt_q != LONG_LAST) begin
               hold_cnt_d = hold_cnt_q + LONG_W'(1);
            end else if (!long_done_q) begin
               long_d      = 1'b1;
               long_done_d = 1'b1;
            end
            if (!s) begin
               state_d  = WAIT_R;
               db_cnt_d = '0;
            end
         end

         WAIT_R: begin
            db_d = 1'b1;
            if (db_cnt_q == DB_LAST) begin
               state_d = REL;
               db_d    = 1'b0;
               fall_d  = 1'b1;
            end else if (s) begin
               state_d = PRS;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end

         default: begin
            state_d = REL;
            db_d    = 1'b0;
         end
      endcase
   end

   assign db        = db_q;
   assign rise_tick = rise_q;
   assign fall_tick = fall_q;
   assign long_tick = long_q;

endmodule

// File: doc/switch_debouncer_fsm.md
Name: switch_debouncer_fsm

Overview:
- Upstream conditioning stage for the board push-buttons: synchronizes a raw, bouncing, active-low switch, debounces it with an explicit 4-state FSM, and emits a clean active-high level.
- Also emits one-cycle rise, fall and long-press ticks.
- Outputs feed the edge-detector / mod-10 counter / seven-segment display path directly, so downstream counters need no extra edge logic.

Parameters:
- DB_CYCLES, 500000, stable-input cycles required to accept a change (10 ms at 50 MHz); must be >= 2.
- LONG_CYCLES, 50000000, cycles of debounced-pressed hold before long_tick fires (1 s at 50 MHz); must be > DB_CYCLES.
- SW_ACTIVE_LOW, 1, 1 = raw input is active-low (inverted internally); 0 = active-high.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- sw  input  1  raw asynchronous switch input, polarity per SW_ACTIVE_LOW.
- db  output  1  debounced level, active-high (1 = pressed).
- rise_tick  output  1  one-cycle pulse on debounced press.
- fall_tick  output  1  one-cycle pulse on debounced release.
- long_tick  output  1  one-cycle pulse once per press after LONG_CYCLES of hold.

Behaviour:
- Reset:
  - Asynchronous; all flops clear.
  - State = REL, db = 0, all ticks = 0, counters = 0.
  - Synchronizer resets to the inactive (released) level.
- Input path:
  - sw_act = SW_ACTIVE_LOW ? ~sw : sw.
  - Passes through a 2-flop synchronizer; the FSM sees only sync output s.
- FSM states: REL (stable released), WAIT_P (candidate press), PRS (stable pressed), WAIT_R (candidate release).
- REL:
  - db = 0.
  - s = 1 -> WAIT_P, db_cnt <= 0.
- WAIT_P:
  - s = 0 -> REL; no tick.
  - s = 1 -> db_cnt increments.
  - At db_cnt == DB_CYCLES-1 with s = 1 -> PRS; db <= 1; rise_tick = 1 for that one cycle; hold_cnt <= 0.
- PRS:
  - db = 1; hold_cnt increments each cycle until saturated.
  - At hold_cnt == LONG_CYCLES-1 -> long_tick = 1 for one cycle; hold_cnt then saturates. No repeat within the same press.
  - s = 0 -> WAIT_R, db_cnt <= 0.
- WAIT_R:
  - db stays 1; hold_cnt pauses.
  - s = 1 -> PRS; hold_cnt resumes, not cleared.
  - At db_cnt == DB_CYCLES-1 with s = 0 -> REL; db <= 0; fall_tick = 1 for one cycle.
- Outputs: db and all ticks are registered and glitch-free.
- Latency: a clean edge on sw settling before clock edge k gives db (and rise_tick / fall_tick) changing at edge k+2+DB_CYCLES.
- Boundary conditions:
  - Any glitch shorter than DB_CYCLES cycles (after sync) produces no db change and no tick.
  - A glitch of exactly DB_CYCLES-1 cycles is rejected; exactly DB_CYCLES cycles is accepted.
  - rise_tick, fall_tick and long_tick are mutually exclusive by construction; never simultaneous.
  - long_tick is impossible unless db = 1.
  - A press released before LONG_CYCLES gives no long_tick.
- Reset mid-operation:
  - Returns to REL immediately.
  - If sw is still pressed at reset release, it is treated as a fresh press: rise_tick fires DB_CYCLES+2 cycles after reset deassertion.
- Width rules:
  - db_cnt width = $clog2(DB_CYCLES); hold_cnt width = $clog2(LONG_CYCLES).
  - Counters never wrap; compares use ==, with hold_cnt saturating.

Decomposition:
- Shared package / header:
  - FSM state encodings (REL = 2'd0, WAIT_P = 2'd1, PRS = 2'd2, WAIT_R = 2'd3).
  - Default timing constants (DB_10MS_50MHZ, LONG_1S_50MHZ), reused by other button blocks.
- One sub-module: sync_2ff (1-bit, 2-flop synchronizer with async active-low reset and parameterized reset value).
- The FSM, counters and tick generation stay in this module.

Test Plan:
All scenarios use DB_CYCLES = 8, LONG_CYCLES = 40, SW_ACTIVE_LOW = 1.
- Clean press: sw 1 -> 0 before edge 0, held -> db = 1 and rise_tick = 1 exactly at edge 10; rise_tick = 0 at edge 11; no other ticks.
- Bounce rejection: sw low for 7 cycles, high for 3, low for 7, then high -> db stays 0; no ticks.
- Acceptance threshold: sw low for exactly 8 cycles then high -> db high for >= 1 cycle; one rise_tick; fall_tick after release debounces.
- Long press: sw held low for 60 cycles -> rise_tick at edge 10; single long_tick at edge 50; no second long_tick. Release then gives fall_tick 10 cycles after the release edge.
- Release bounce: while pressed, sw high for 5 cycles then low again -> db stays 1; no fall_tick; hold_cnt resumes, not cleared.
- Reset mid-press: assert rst_n = 0 while db = 1 -> db and all ticks go 0 immediately. Deassert with sw still low -> rise_tick 10 cycles after deassertion.
